// File: rtl/test_pattern_generator.sv
// Programmable stimulus source: table, ramp, LFSR or constant words
// streamed over a valid/ready port with run length, loop and abort.
module test_pattern_generator #(
    parameter int DATA_W  = 64,
    parameter int TABLE_W = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [15:0]        length,
    input  logic               loop,
    input  logic [DATA_W-1:0]  seed,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [TABLE_W-1:0] wr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic [31:0]        beat_cnt
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [1:0]  M_TABLE   = 2'd0;
    localparam logic [1:0]  M_RAMP    = 2'd1;
    localparam logic [1:0]  M_LFSR    = 2'd2;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    state_t              r_state, w_state_nx;
    logic [1:0]          r_mode, w_mode_nx;
    logic [15:0]         r_len, w_len_nx;
    logic                r_loop, w_loop_nx;
    logic [DATA_W-1:0]   r_seed, w_seed_nx;
    logic [15:0]         r_idx, w_idx_nx;
    logic [31:0]         r_lfsr, w_lfsr_nx;
    logic [DATA_W-1:0]   r_data, w_data_nx;
    logic                r_valid, w_valid_nx;
    logic                r_done, w_done_nx;
    logic                r_wrap, w_wrap_nx;
    logic [31:0]         r_beat, w_beat_nx;
    logic [TABLE_W-1:0]  r_table [DEPTH];

    logic                w_accept;
    logic                w_last;
    logic [15:0]         w_idx_inc;
    logic [31:0]         w_beat_inc;
    logic [31:0]         w_lfsr_inc;
    logic [31:0]         w_seed32;
    logic [31:0]         w_seed_lfsr;
    logic [TABLE_W-1:0]  w_tbl_first;
    logic [TABLE_W-1:0]  w_tbl_next;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Word for one pattern mode; narrow sources are zero-extended
    // and the LFSR is truncated when DATA_W is below 32.
    function automatic logic [DATA_W-1:0] pick(
        input logic [1:0]         m,
        input logic [TABLE_W-1:0] t,
        input logic [DATA_W-1:0]  ramp,
        input logic [31:0]        l,
        input logic [DATA_W-1:0]  c
    );
        logic [DATA_W-1:0] w;
        case (m)
            M_TABLE: w = DATA_W'({{DATA_W{1'b0}}, t});
            M_RAMP:  w = ramp;
            M_LFSR:  w = DATA_W'({{DATA_W{1'b0}}, l});
            default: w = c;
        endcase
        return w;
    endfunction

    assign w_accept    = r_valid && out_ready;
    assign w_last      = (r_len != 16'd0) && (r_idx == r_len - 16'd1);
    assign w_idx_inc   = w_last ? 16'd0 : r_idx + 16'd1;
    assign w_beat_inc  = r_beat + 32'd1;
    assign w_lfsr_inc  = lfsr_step(r_lfsr);
    assign w_seed32    = 32'({{32{1'b0}}, seed});
    assign w_seed_lfsr = (w_seed32 == 32'd0) ? 32'd1 : w_seed32;
    assign w_tbl_first = r_table[{ADDR_W{1'b0}}];
    assign w_tbl_next  = r_table[w_idx_inc[ADDR_W-1:0]];

    // Pattern table write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-word logic
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_len_nx   = r_len;
        w_loop_nx  = r_loop;
        w_seed_nx  = r_seed;
        w_idx_nx   = r_idx;
        w_lfsr_nx  = r_lfsr;
        w_data_nx  = r_data;
        w_valid_nx = r_valid;
        w_beat_nx  = r_beat;
        w_done_nx  = 1'b0;
        w_wrap_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nx = S_RUN;
                    w_mode_nx  = mode;
                    w_len_nx   = length;
                    w_loop_nx  = loop;
                    w_seed_nx  = seed;
                    w_idx_nx   = 16'd0;
                    w_lfsr_nx  = w_seed_lfsr;
                    w_data_nx  = pick(mode, w_tbl_first, seed,
                                      w_seed_lfsr, seed);
                    w_valid_nx = 1'b1;
                    w_beat_nx  = 32'd0;
                end
            end
            default: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                end else if (w_accept) begin
                    w_beat_nx = w_beat_inc;
                    if (w_last && !r_loop) begin
                        w_state_nx = S_IDLE;
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_idx_nx  = w_idx_inc;
                        w_lfsr_nx = w_lfsr_inc;
                        w_wrap_nx = w_last;
                        w_data_nx = pick(r_mode, w_tbl_next,
                                         r_seed + DATA_W'(w_beat_inc),
                                         w_lfsr_inc, r_seed);
                    end
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_len   <= 16'd0;
            r_loop  <= 1'b0;
            r_seed  <= '0;
            r_idx   <= 16'd0;
            r_lfsr  <= 32'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_beat  <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_len   <= w_len_nx;
            r_loop  <= w_loop_nx;
            r_seed  <= w_seed_nx;
            r_idx   <= w_idx_nx;
            r_lfsr  <= w_lfsr_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_wrap  <= w_wrap_nx;
            r_beat  <= w_beat_nx;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign beat_cnt  = r_beat;

endmodule
